// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline.
// Tracks the destination state of the EX and MEM stages, issues registered
// operand-forwarding selects for the EX stage, and generates load-use stalls,
// branch flushes and the multi-cycle hold that wraps an MDU operation in EX.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   id_is_mdu,
    input  logic                   branch_taken_ex,
    input  logic                   mdu_done,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_hold,
    output logic                   mdu_start,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    // What the tracking pipeline does on the coming edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE, // MEM<=EX, EX<=ID, flags<=computed
        ACT_BUBBLE,  // MEM<=EX, EX<=bubble, flags<=00
        ACT_HOLD     // EX frozen, MEM<=bubble, flags held
    } act_t;

    state_t state_reg, state_next;
    act_t   act;

    // EX-stage producer
    logic                  ex_v_reg;
    logic [REG_ADDR_W-1:0] ex_rd_reg;
    logic                  ex_we_reg;
    logic                  ex_mr_reg;
    logic                  ex_mdu_reg;

    // MEM-stage producer. Its load flag is not kept: MEM/WB data already
    // carries the load result, so a load in MEM forwards like any writer.
    logic                  mem_v_reg;
    logic [REG_ADDR_W-1:0] mem_rd_reg;
    logic                  mem_we_reg;

    logic [1:0]             fwd_a_reg;
    logic [1:0]             fwd_b_reg;
    logic [STALL_CNT_W-1:0] stall_cycles_reg;

    logic [1:0][REG_ADDR_W-1:0] src_addr;
    logic [1:0]                 src_used;
    logic [1:0]                 hit_ex;
    logic [1:0]                 hit_mem;
    logic [1:0][1:0]            fwd_next;
    logic                       load_use;

    assign src_addr[0] = id_rs1;
    assign src_addr[1] = id_rs2;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    // Per-source match against each producer and the resulting select code.
    // A load in EX never yields 01: its data does not exist until MEM.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit_ex[gi]  = ex_v_reg & ex_we_reg & (ex_rd_reg != '0)
                               & src_used[gi] & (src_addr[gi] == ex_rd_reg);
            assign hit_mem[gi] = mem_v_reg & mem_we_reg & (mem_rd_reg != '0)
                               & src_used[gi] & (src_addr[gi] == mem_rd_reg);
            assign fwd_next[gi] = (hit_ex[gi] & ~ex_mr_reg) ? 2'b01 :
                                  (hit_mem[gi]            ? 2'b10 : 2'b00);
        end
    endgenerate

    assign load_use = (state_reg == RUN) & id_valid & ex_v_reg & ex_mr_reg & (|hit_ex);

    // Pipeline control decode: MDU launch/wait first, then flush, then load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        mdu_start    = 1'b0;
        act          = ACT_ADVANCE;
        state_next   = state_reg;
        if (state_reg == MDU_WAIT) begin
            if (!mdu_done) begin
                ex_hold     = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                act         = ACT_HOLD;
            end else begin
                state_next = RUN;
            end
        end else if (ex_v_reg && ex_mdu_reg) begin
            mdu_start   = 1'b1;
            ex_hold     = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            act         = ACT_HOLD;
            state_next  = MDU_WAIT;
        end else if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            act          = ACT_BUBBLE;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            act          = ACT_BUBBLE;
        end
    end

    // State, tracking entries, forwarding selects and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= RUN;
            ex_v_reg         <= 1'b0;
            ex_rd_reg        <= '0;
            ex_we_reg        <= 1'b0;
            ex_mr_reg        <= 1'b0;
            ex_mdu_reg       <= 1'b0;
            mem_v_reg        <= 1'b0;
            mem_rd_reg       <= '0;
            mem_we_reg       <= 1'b0;
            fwd_a_reg        <= 2'b00;
            fwd_b_reg        <= 2'b00;
            stall_cycles_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (!pc_write) begin
                stall_cycles_reg <= stall_cycles_reg + STALL_CNT_W'(1);
            end
            case (act)
                ACT_ADVANCE: begin
                    mem_v_reg  <= ex_v_reg;
                    mem_rd_reg <= ex_rd_reg;
                    mem_we_reg <= ex_we_reg;
                    ex_v_reg   <= id_valid;
                    ex_rd_reg  <= id_rd;
                    ex_we_reg  <= id_regwrite;
                    ex_mr_reg  <= id_memread;
                    ex_mdu_reg <= id_is_mdu;
                    fwd_a_reg  <= fwd_next[0];
                    fwd_b_reg  <= fwd_next[1];
                end
                ACT_BUBBLE: begin
                    mem_v_reg  <= ex_v_reg;
                    mem_rd_reg <= ex_rd_reg;
                    mem_we_reg <= ex_we_reg;
                    ex_v_reg   <= 1'b0;
                    ex_rd_reg  <= '0;
                    ex_we_reg  <= 1'b0;
                    ex_mr_reg  <= 1'b0;
                    ex_mdu_reg <= 1'b0;
                    fwd_a_reg  <= 2'b00;
                    fwd_b_reg  <= 2'b00;
                end
                default: begin
                    mem_v_reg  <= 1'b0;
                    mem_rd_reg <= '0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign forward_a    = fwd_a_reg;
    assign forward_b    = fwd_b_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule
